// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, defaults and round-robin helper for the IIR channel scheduler
package iir_pkg;

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = 5;
    localparam int RR_MAX_N  = 32;
    localparam int RR_IDX_W  = 5;

    typedef enum logic {
        IDLE,
        EXEC
    } sched_state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scans from the highest offset down so the last hit is the one closest to ptr.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int n);
        rr_pick_t r;
        int       k;
        r = '0;
        for (int i = RR_MAX_N - 1; i >= 0; i--) begin
            if (i < n) begin
                k = (int'(ptr) + i) % n;
                if (req[k[RR_IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = k[RR_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/iir1_datapath.sv
// rtl/iir1_datapath.sv - combinational first-order IIR step y = ym1/4 + x/2
module iir1_datapath #(
    parameter int W = 5
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] ym1,
    output logic [W-1:0] y
);

    // Arithmetic shifts floor toward -inf; the sum cannot leave the W-bit range.
    assign y = ($signed(ym1) >>> 2) + ($signed(x) >>> 1);

endmodule

// File: rtl/iir1_channel_scheduler.sv
// rtl/iir1_channel_scheduler.sv - round-robin sharing of one IIR datapath across N channels
module iir1_channel_scheduler
    import iir_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT,
    localparam int CW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  x_in,
    input  logic [N-1:0]    clr,
    output logic [N-1:0]    ack,
    output logic [W-1:0]    y_out,
    output logic [CW-1:0]   y_ch,
    output logic            y_val
);

    sched_state_t  state, state_nxt;
    logic [CW-1:0] ptr;
    logic [CW-1:0] k_lat;
    logic [W-1:0]  x_lat;
    logic [W-1:0]  bank [N];
    logic [W-1:0]  x_arr [N];
    logic [W-1:0]  y_calc;
    logic [CW-1:0] grant;
    logic          pick_found;
    logic          do_grant;
    logic          do_exec;

    for (genvar g = 0; g < N; g++) begin : g_xsplit
        assign x_arr[g] = x_in[g*W +: W];
    end

    always_comb begin
        rr_pick_t p;
        p          = rr_pick(RR_MAX_N'(req), RR_IDX_W'(ptr), N);
        pick_found = p.found;
        grant      = CW'(p.idx);
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_exec   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    do_grant  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                do_exec   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    iir1_datapath #(.W(W)) u_datapath (
        .x   (x_lat),
        .ym1 (bank[k_lat]),
        .y   (y_calc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            k_lat <= '0;
            x_lat <= '0;
            ack   <= '0;
            y_out <= '0;
            y_ch  <= '0;
            y_val <= 1'b0;
        end else begin
            ack   <= '0;
            y_val <= 1'b0;
            if (do_grant) begin
                x_lat      <= x_arr[grant];
                k_lat      <= grant;
                ack[grant] <= 1'b1;
            end
            if (do_exec) begin
                y_out <= y_calc;
                y_ch  <= k_lat;
                y_val <= 1'b1;
                ptr   <= (k_lat == CW'(N - 1)) ? '0 : k_lat + 1'b1;
            end
        end
    end

    // A clear on the channel being written takes priority over the new result.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (rst || clr[j]) begin
                bank[j] <= '0;
            end else if (do_exec && k_lat == CW'(j)) begin
                bank[j] <= y_calc;
            end
        end
    end

endmodule

// File: tb/tb_iir1_channel_scheduler.sv
// tb/tb_iir1_channel_scheduler.sv - scoreboard bench for the IIR channel scheduler
module tb_iir1_channel_scheduler;

    localparam int N = 4;
    localparam int W = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] x_in;
    logic [N-1:0]   clr;
    logic [N-1:0]   ack;
    logic [W-1:0]   y_out;
    logic [1:0]     y_ch;
    logic           y_val;

    always #5 clk = ~clk;

    iir1_channel_scheduler #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .x_in  (x_in),
        .clr   (clr),
        .ack   (ack),
        .y_out (y_out),
        .y_ch  (y_ch),
        .y_val (y_val)
    );

    typedef struct {
        int ch;
        int y;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t log_q[$];
    int   chq[N][$];

    int         st[N];
    bit         busy = 1'b0;
    int         mg = 0;
    int         mx = 0;
    int         mptr = 0;
    logic [N-1:0] exp_ack = '0;
    bit         exp_rst = 1'b0;
    bit         mon_en = 1'b0;
    bit         rst_hold = 1'b1;
    bit         clr_on_exec1 = 1'b0;
    bit         rst_on_exec = 1'b0;
    logic [N-1:0] clr_rand = '0;

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic check_log(input int idx, input int ch, input int y);
        if (idx >= log_q.size()) begin
            checks++;
            errors++;
            $display("FAIL log_missing: got %0d results, expected entry %0d", log_q.size(), idx);
        end else begin
            check("log_ch", log_q[idx].ch, ch);
            check("log_y", log_q[idx].y, y);
        end
    endtask

    // Reference model: one call per rising edge, using the inputs presented for that edge.
    task automatic model_step();
        int   y;
        bit   found;
        res_t r;
        if (rst) begin
            for (int j = 0; j < N; j++) st[j] = 0;
            busy    = 1'b0;
            mptr    = 0;
            exp_ack = '0;
            exp_rst = 1'b1;
        end else if (busy) begin
            y    = fdiv(st[mg], 4) + fdiv(mx, 2);
            r.ch = mg;
            r.y  = y;
            exp_q.push_back(r);
            st[mg]  = y;
            busy    = 1'b0;
            exp_ack = '0;
            for (int j = 0; j < N; j++) if (clr[j]) st[j] = 0;
        end else begin
            for (int j = 0; j < N; j++) if (clr[j]) st[j] = 0;
            exp_ack = '0;
            found   = 1'b0;
            for (int i = 0; i < N; i++) begin
                int c;
                c = (mptr + i) % N;
                if (!found && req[c]) begin
                    found = 1'b1;
                    mg    = c;
                end
            end
            if (found) begin
                mx          = chq[mg][0];
                busy        = 1'b1;
                mptr        = (mg + 1) % N;
                exp_ack[mg] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (ack[k] && chq[k].size() > 0) void'(chq[k].pop_front());
        end
        for (int k = 0; k < N; k++) begin
            req[k]          = (chq[k].size() > 0);
            x_in[k*W +: W]  = req[k] ? W'(chq[k][0]) : '0;
        end
        clr = clr_rand;
        rst = rst_hold;
        if (busy && clr_on_exec1 && mg == 1) begin
            clr[1]       = 1'b1;
            clr_on_exec1 = 1'b0;
        end
        if (busy && rst_on_exec) begin
            rst         = 1'b1;
            rst_on_exec = 1'b0;
        end
        model_step();
        clr_rand = '0;
    endtask

    task automatic drain();
        int  n;
        bit  pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < 200) begin
            pending = busy || (exp_q.size() > 0);
            for (int k = 0; k < N; k++) if (chq[k].size() > 0) pending = 1'b1;
            if (pending) begin
                tick();
                n++;
            end
        end
        if (pending) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got pending work after %0d cycles, expected idle", n);
        end
    endtask

    task automatic push_n(input int ch, input int x, input int cnt);
        for (int i = 0; i < cnt; i++) chq[ch].push_back(x);
    endtask

    always @(posedge clk) begin
        res_t e;
        res_t o;
        #1;
        if (mon_en) begin
            check("ack", int'(ack), int'(exp_ack));
            check("y_val", int'(y_val), int'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (y_val) begin
                    check("y_ch", int'(y_ch), e.ch);
                    check("y_out", int'($signed(y_out)), e.y);
                    o.ch = int'(y_ch);
                    o.y  = int'($signed(y_out));
                    log_q.push_back(o);
                end
            end
            if (exp_rst) begin
                check("rst_y_out", int'(y_out), 0);
                check("rst_y_ch", int'(y_ch), 0);
                exp_rst = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        req  = '0;
        clr  = '0;
        x_in = '0;
        tick();
        mon_en = 1'b1;
        tick();
        rst_hold = 1'b0;
        tick();

        log_q.delete();
        push_n(0, 8, 4);
        drain();
        check("t1_count", log_q.size(), 4);
        check_log(0, 0, 4);
        check_log(1, 0, 5);
        check_log(2, 0, 5);
        check_log(3, 0, 5);

        log_q.delete();
        push_n(2, -8, 4);
        drain();
        check_log(0, 2, -4);
        check_log(1, 2, -5);
        check_log(2, 2, -6);
        check_log(3, 2, -6);

        log_q.delete();
        push_n(1, 8, 3);
        drain();
        push_n(3, -8, 1);
        drain();
        push_n(1, 8, 1);
        drain();
        check_log(3, 3, -4);
        check_log(4, 1, 5);

        log_q.delete();
        clr_on_exec1 = 1'b1;
        push_n(1, 8, 1);
        drain();
        push_n(1, 8, 1);
        drain();
        check_log(0, 1, 5);
        check_log(1, 1, 4);

        rst_hold = 1'b1;
        tick();
        rst_hold = 1'b0;
        log_q.delete();
        for (int k = 0; k < N; k++) push_n(k, 6 - 4 * k, 3);
        drain();
        check("rr_count", log_q.size(), 12);
        for (int i = 0; i < log_q.size(); i++) check("rr_order", log_q[i].ch, i % N);

        log_q.delete();
        rst_on_exec = 1'b1;
        push_n(0, 8, 1);
        drain();
        push_n(0, 8, 1);
        drain();
        check("rst_drop_count", log_q.size(), 1);
        check_log(0, 0, 4);

        for (int c = 0; c < 600; c++) begin
            int ch;
            if ($urandom_range(0, 3) == 0) begin
                ch = $urandom_range(0, N - 1);
                if (chq[ch].size() < 3) chq[ch].push_back(int'($urandom_range(0, 31)) - 16);
            end
            if ($urandom_range(0, 15) == 0) clr_rand = N'($urandom);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
